// File: rtl/eq_gain_ctrl_pkg.sv
// eq_ctrl_pkg: shared constants and helpers for the equaliser control front end.
//   - Seven-segment patterns, active-low, bit0 = segment a
//   - seg_dec  : one decimal digit -> segment pattern (non-digits blank)
//   - bin2tu   : 0..99 binary value -> {tens, units} BCD nibbles
//   - seg_disp : full six-digit readout "b<band>  <gain>"
package eq_ctrl_pkg;

    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index n holds the pattern for digit n.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_dec(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_DIGITS[d] : SEG_BLANK;
    endfunction

    function automatic logic [7:0] bin2tu(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 7'd10);
        units = 4'(v - (v / 7'd10) * 7'd10);
        return {tens, units};
    endfunction

    // band_dig is the 1-based band number shown to the user.
    function automatic logic [5:0][6:0] seg_disp(input logic [3:0] band_dig,
                                                 input logic [6:0] gain);
        logic [7:0] tu;
        logic [6:0] tens_seg;
        tu       = bin2tu(gain);
        tens_seg = (tu[7:4] == 4'd0) ? SEG_BLANK : seg_dec(tu[7:4]);
        return {SEG_B, seg_dec(band_dig), SEG_BLANK, SEG_BLANK,
                tens_seg, seg_dec(tu[3:0])};
    endfunction

endpackage

// File: rtl/eq_gain_ctrl_key_cond.sv
// key_cond: conditions one active-low asynchronous push-button.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   key_ni        : raw button level (0 = pressed)
//   press_o       : one-cycle event per accepted press, plus auto-repeat
//                   events while held when REPEAT_EN = 1
module key_cond
    import eq_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 25_000_000,
    parameter int REPEAT_CYC   = 5_000_000,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic press_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int RC_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int RC_W   = $clog2(RC_MAX + 1);

    logic [1:0]      sync_q, sync_d;
    logic [1:0]      vld_q, vld_d;
    logic            deb_q, deb_d;
    logic            deb_prev_q, deb_prev_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            armed_q, armed_d;
    logic [RC_W-1:0] rc_cnt_q, rc_cnt_d;
    logic            rep_q, rep_d;
    logic            fall;
    logic            rep_ev;

    always_comb begin
        sync_d     = {sync_q[0], key_ni};
        vld_d      = (vld_q == 2'd2) ? vld_q : vld_q + 2'd1;
        deb_prev_d = deb_q;

        deb_d    = deb_q;
        db_cnt_d = '0;
        if (sync_q[1] != deb_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
                deb_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        // The sync flops hold reset values for two cycles; only once they carry
        // real samples may a released level arm the event generator. A key held
        // through reset therefore never arms until it is seen released.
        armed_d = armed_q;
        if ((vld_q == 2'd2) && sync_q[1] && deb_q) begin
            armed_d = 1'b1;
        end

        fall = deb_prev_q & ~deb_q;

        // rc_cnt_q is 0 in the press cycle and counts cycles held since then.
        rep_ev   = 1'b0;
        rep_d    = 1'b0;
        rc_cnt_d = '0;
        if (!deb_q && REPEAT_EN) begin
            rep_d    = rep_q;
            rc_cnt_d = rc_cnt_q + RC_W'(1);
            if (!rep_q && (rc_cnt_q == RC_W'(HOLD_CYC))) begin
                rep_ev   = 1'b1;
                rep_d    = 1'b1;
                rc_cnt_d = RC_W'(1);
            end else if (rep_q && (rc_cnt_q == RC_W'(REPEAT_CYC))) begin
                rep_ev   = 1'b1;
                rc_cnt_d = RC_W'(1);
            end
        end

        press_o = armed_q & (fall | rep_ev);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q     <= 2'b11;
            vld_q      <= 2'd0;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            db_cnt_q   <= '0;
            armed_q    <= 1'b0;
            rc_cnt_q   <= '0;
            rep_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            vld_q      <= vld_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            db_cnt_q   <= db_cnt_d;
            armed_q    <= armed_d;
            rc_cnt_q   <= rc_cnt_d;
            rep_q      <= rep_d;
        end
    end

endmodule

// File: rtl/eq_gain_ctrl.sv
// eq_gain_ctrl: push-button front end of the N-band FIR equaliser.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   key_band_ni        : band-select button (active-low, async)
//   key_up_ni          : gain-up button (active-low, async, auto-repeat)
//   key_dn_ni          : gain-down button (active-low, async, auto-repeat)
//   band_o             : selected band
//   gain_o             : gain index per band
//   upd_o, upd_band_o  : one-cycle pulse and band index when a gain changes
//   hex_o              : six 7-segment digits "b<band>  <gain>", active-low
module eq_gain_ctrl
    import eq_ctrl_pkg::*;
#(
    parameter int NUM_BANDS    = 3,
    parameter int GAIN_WD      = 3,
    parameter int GAIN_MAX     = 5,
    parameter int GAIN_RST     = 0,
    parameter int WRAP         = 0,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 25_000_000,
    parameter int REPEAT_CYC   = 5_000_000,
    localparam int BAND_W      = $clog2(NUM_BANDS)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                key_band_ni,
    input  logic                                key_up_ni,
    input  logic                                key_dn_ni,
    output logic [BAND_W-1:0]                   band_o,
    output logic [NUM_BANDS-1:0][GAIN_WD-1:0]   gain_o,
    output logic                                upd_o,
    output logic [BAND_W-1:0]                   upd_band_o,
    output logic [5:0][6:0]                     hex_o
);

    logic press_band, press_up, press_dn;

    key_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC),
               .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0))
        u_key_band (.clk_i(clk_i), .rst_ni(rst_ni), .key_ni(key_band_ni), .press_o(press_band));

    key_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC),
               .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1))
        u_key_up (.clk_i(clk_i), .rst_ni(rst_ni), .key_ni(key_up_ni), .press_o(press_up));

    key_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC),
               .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1))
        u_key_dn (.clk_i(clk_i), .rst_ni(rst_ni), .key_ni(key_dn_ni), .press_o(press_dn));

    logic [BAND_W-1:0]              band_q, band_d;
    logic [NUM_BANDS-1:0][GAIN_WD-1:0] gain_q, gain_d;
    logic                           upd_q, upd_d;
    logic [BAND_W-1:0]              upd_band_q, upd_band_d;
    logic [5:0][6:0]                hex_q, hex_d;
    logic [GAIN_WD-1:0]             cur, nxt;

    always_comb begin
        band_d     = band_q;
        gain_d     = gain_q;
        upd_d      = 1'b0;
        upd_band_d = upd_band_q;

        // Gain step always targets the band selected before this cycle's
        // band event; opposing up/down events cancel.
        cur = gain_q[band_q];
        nxt = cur;
        if (press_up && !press_dn) begin
            if (cur == GAIN_WD'(GAIN_MAX)) begin
                nxt = (WRAP != 0) ? '0 : cur;
            end else begin
                nxt = cur + GAIN_WD'(1);
            end
        end else if (press_dn && !press_up) begin
            if (cur == '0) begin
                nxt = (WRAP != 0) ? GAIN_WD'(GAIN_MAX) : cur;
            end else begin
                nxt = cur - GAIN_WD'(1);
            end
        end

        if (nxt != cur) begin
            gain_d[band_q] = nxt;
            upd_d          = 1'b1;
            upd_band_d     = band_q;
        end

        if (press_band) begin
            band_d = (band_q == BAND_W'(NUM_BANDS - 1)) ? '0 : band_q + BAND_W'(1);
        end

        hex_d = seg_disp(4'(band_q) + 4'd1, 7'(gain_q[band_q]));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            band_q     <= '0;
            gain_q     <= {NUM_BANDS{GAIN_WD'(GAIN_RST)}};
            upd_q      <= 1'b0;
            upd_band_q <= '0;
            hex_q      <= seg_disp(4'd1, 7'(GAIN_RST));
        end else begin
            band_q     <= band_d;
            gain_q     <= gain_d;
            upd_q      <= upd_d;
            upd_band_q <= upd_band_d;
            hex_q      <= hex_d;
        end
    end

    assign band_o     = band_q;
    assign gain_o     = gain_q;
    assign upd_o      = upd_q;
    assign upd_band_o = upd_band_q;
    assign hex_o      = hex_q;

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Bench for eq_gain_ctrl: two instances (saturating and wrapping) share the
// same key stimulus; a reference model pushes every expected gain update to a
// per-instance queue, which the monitors pop whenever upd_o pulses.
module tb_eq_gain_ctrl;

    localparam int NB = 3;
    localparam int GW = 3;
    localparam int GM = 5;
    localparam int HOLD = 8;
    localparam int REP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic k_band = 1'b1, k_up = 1'b1, k_dn = 1'b1;

    logic [1:0]             band0, band1, ub0, ub1;
    logic [NB-1:0][GW-1:0]  g0, g1;
    logic                   u0, u1;
    logic [5:0][6:0]        h0, h1;

    eq_gain_ctrl #(.NUM_BANDS(NB), .GAIN_WD(GW), .GAIN_MAX(GM), .GAIN_RST(0), .WRAP(0),
                   .DEBOUNCE_CYC(4), .HOLD_CYC(HOLD), .REPEAT_CYC(REP))
        dut_sat (.clk_i(clk), .rst_ni(rst_n), .key_band_ni(k_band), .key_up_ni(k_up),
                 .key_dn_ni(k_dn), .band_o(band0), .gain_o(g0), .upd_o(u0),
                 .upd_band_o(ub0), .hex_o(h0));

    eq_gain_ctrl #(.NUM_BANDS(NB), .GAIN_WD(GW), .GAIN_MAX(GM), .GAIN_RST(0), .WRAP(1),
                   .DEBOUNCE_CYC(4), .HOLD_CYC(HOLD), .REPEAT_CYC(REP))
        dut_wrap (.clk_i(clk), .rst_ni(rst_n), .key_band_ni(k_band), .key_up_ni(k_up),
                  .key_dn_ni(k_dn), .band_o(band1), .gain_o(g1), .upd_o(u1),
                  .upd_band_o(ub1), .hex_o(h1));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int band;
        int gain;
    } upd_t;

    upd_t q0[$];
    upd_t q1[$];
    upd_t e0, e1;

    int m_band[2];
    int m_gain[2][NB];
    int m_wrap[2] = '{0, 1};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_band[d] = 0;
            for (int i = 0; i < NB; i++) m_gain[d][i] = 0;
        end
    endtask

    task automatic model_step(input bit b, input bit u, input bit dn);
        for (int d = 0; d < 2; d++) begin
            int g;
            int n;
            upd_t e;
            g = m_gain[d][m_band[d]];
            n = g;
            if (u && !dn) n = (g == GM) ? ((m_wrap[d] != 0) ? 0 : g) : g + 1;
            if (dn && !u) n = (g == 0) ? ((m_wrap[d] != 0) ? GM : g) : g - 1;
            if (n != g) begin
                m_gain[d][m_band[d]] = n;
                e.band = m_band[d];
                e.gain = n;
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
            if (b) m_band[d] = (m_band[d] + 1) % NB;
        end
    endtask

    // Debounced level stays low for exactly L cycles; events land at offsets
    // 0, HOLD, HOLD+REP, ... within that window.
    function automatic int n_events(input int L, input bit rep);
        if (!rep || (L - 1) < HOLD) return 1;
        return 2 + (L - 1 - HOLD) / REP;
    endfunction

    task automatic press(input bit b, input bit u, input bit dn, input int L);
        int nb, nu, nd, nmax;
        @(posedge clk); #1;
        if (b)  k_band = 1'b0;
        if (u)  k_up   = 1'b0;
        if (dn) k_dn   = 1'b0;
        nb = b  ? 1 : 0;
        nu = u  ? n_events(L, 1'b1) : 0;
        nd = dn ? n_events(L, 1'b1) : 0;
        nmax = (nu > nd) ? nu : nd;
        if (nb > nmax) nmax = nb;
        for (int i = 0; i < nmax; i++) model_step(i < nb, i < nu, i < nd);
        repeat (L) @(posedge clk);
        #1;
        k_band = 1'b1; k_up = 1'b1; k_dn = 1'b1;
        repeat (12) @(posedge clk);
    endtask

    function automatic logic [41:0] exp_hex(input int band, input int gain);
        logic [6:0] seg [10];
        logic [6:0] tens_seg;
        seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        tens_seg = ((gain / 10) == 0) ? 7'h7F : seg[gain / 10];
        return {7'h03, seg[band + 1], 7'h7F, 7'h7F, tens_seg, seg[gain % 10]};
    endfunction

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, " band0"}, 64'(band0), 64'(m_band[0]));
        check({tag, " band1"}, 64'(band1), 64'(m_band[1]));
        for (int i = 0; i < NB; i++) begin
            check($sformatf("%s gain0[%0d]", tag, i), 64'(g0[i]), 64'(m_gain[0][i]));
            check($sformatf("%s gain1[%0d]", tag, i), 64'(g1[i]), 64'(m_gain[1][i]));
        end
        check({tag, " hex0"}, 64'(h0), 64'(exp_hex(m_band[0], m_gain[0][m_band[0]])));
        check({tag, " hex1"}, 64'(h1), 64'(exp_hex(m_band[1], m_gain[1][m_band[1]])));
    endtask

    always @(negedge clk) begin
        if (rst_n && u0) begin
            if (q0.size() == 0) begin
                check("upd0_unexpected", 64'(u0), 64'(0));
            end else begin
                e0 = q0.pop_front();
                check("upd0_band", 64'(ub0), 64'(e0.band));
                check("upd0_gain", 64'(g0[ub0]), 64'(e0.gain));
            end
        end
        if (rst_n && u1) begin
            if (q1.size() == 0) begin
                check("upd1_unexpected", 64'(u1), 64'(0));
            end else begin
                e1 = q1.pop_front();
                check("upd1_band", 64'(ub1), 64'(e1.band));
                check("upd1_gain", 64'(g1[ub1]), 64'(e1.gain));
            end
        end
    end

    initial begin
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        check_state("reset");
        check("reset upd0", 64'(u0), 64'(0));
        check("reset upd_band1", 64'(ub1), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Bounce shorter than the debounce window, then a real press
        #1;
        for (int i = 0; i < 10; i++) begin
            k_up = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            k_up = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
        press(1'b0, 1'b1, 1'b0, 6);
        check_state("bounce");

        // Climb to GAIN_MAX, then one more press: saturate vs wrap
        for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 1'b0, 6);
        check_state("at_max");
        press(1'b0, 1'b1, 1'b0, 6);
        check_state("past_max");

        // Band wrap, then down on band 1
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0, 6);
        check_state("band_wrap");
        press(1'b1, 1'b0, 1'b0, 6);
        press(1'b0, 1'b0, 1'b1, 6);
        check_state("band1_down");

        // Auto-repeat: held ~30 cycles beyond the press event
        press(1'b0, 1'b1, 1'b0, 36);
        check_state("repeat");

        // Opposing keys together, then band + up together
        press(1'b0, 1'b1, 1'b1, 6);
        check_state("up_dn");
        press(1'b1, 1'b1, 1'b0, 6);
        check_state("band_up");

        // Reset while up is held
        check("queue0_pre_rst", 64'(q0.size()), 64'(0));
        @(posedge clk); #1;
        k_up = 1'b0;
        model_step(1'b0, 1'b1, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        model_reset();
        check_state("held_rst");
        repeat (20) @(posedge clk);
        #1;
        k_up = 1'b1;
        repeat (12) @(posedge clk);
        check_state("held_release");
        press(1'b0, 1'b1, 1'b0, 6);
        check_state("repress");

        check("queue0_left", 64'(q0.size()), 64'(0));
        check("queue1_left", 64'(q1.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
